fft_stream_ctrl: RTL and testbench
==================================

// Module: fft_stream_ctrl
// PURPOSE
//  Scheduler between a valid/ready sample stream and the CE/sync pipelined FFT (fftstage chain).
//  Issues the shared clock-enable (o_fft_ce) only when input is available, output has room and
//  CKPCE spacing allows; generates o_fft_sync on sample 0 of each frame; frames FFT results with
//  m_last; drains in-flight frames on request by feeding zero samples.
// PARAMETERS
//  LGSIZE    9   log2 FFT length N (N = 1<<LGSIZE), >= 3
//  IWIDTH    16  input sample width per real/imag component
//  OWIDTH    21  FFT output width per component
//  CKPCE     1   minimum clocks between o_fft_ce pulses (1..3)
//  LGFLIGHT  4   width of frames-in-flight counter
// PORTS
//  i_clk        in   1           clock
//  i_reset      in   1           sync reset, active high (also drives FFT reset)
//  s_valid      in   1           input sample valid
//  s_ready      out  1           input sample accepted this cycle (s_valid && s_ready)
//  s_data       in   2*IWIDTH    {re,im} input sample
//  s_last       in   1           source marks sample N-1 of its frame
//  o_fft_ce     out  1           FFT clock enable
//  o_fft_sync   out  1           FFT i_sync, only with o_fft_ce
//  o_fft_data   out  2*IWIDTH    FFT i_data
//  i_fft_sync   in   1           FFT o_sync
//  i_fft_data   in   2*OWIDTH    FFT o_data
//  m_valid      out  1           result sample valid
//  m_ready      in   1           downstream accepts result
//  m_data       out  2*OWIDTH    result sample (= i_fft_data)
//  m_last       out  1           result sample N-1 of frame
//  i_flush      in   1           pulse: drain all in-flight frames
//  o_busy       out  1           frames in flight != 0 or not RUN
//  o_err        out  1           sticky: s_last misplaced, out-of-frame sync, or flight overflow
// BEHAVIOUR
//  Reset: state RUN, counters 0, all outputs 0, o_err 0. Reset mid-frame discards everything.
//  fire = (src_ok) && (!m_valid || m_ready) && space_ok; o_fft_ce = fire (combinational).
//   RUN: src_ok = s_valid, s_ready = fire, o_fft_data = s_data. DRAIN/PAD: src_ok = 1, data = 0.
//   space_ok: 0 for CKPCE-1 cycles after each fire (gap counter).
//  in_cnt (LGSIZE bits) +1 per fire, wraps N-1 -> 0. o_fft_sync = fire && in_cnt==0 && RUN.
//  s_last accepted with in_cnt != N-1 -> o_err; s_last absent at N-1 ignored (counter rules).
//  FFT outputs update the cycle after fire (t+1). At t+1: if i_fft_sync, or out_cnt != 0,
//   the new sample belongs to a result frame -> m_valid set; held until m_valid && m_ready.
//   No fire occurs while m_valid && !m_ready, so i_fft_data is stable; m_data = i_fft_data.
//  out_cnt +1 per accepted result; m_last = m_valid && out_cnt==N-1. i_fft_sync with
//   out_cnt != 0 -> o_err, out_cnt restarts at 0 on that sample.
//  flight: +1 on fire with o_fft_sync, -1 on m_last accept; both same cycle -> unchanged.
//   Increment at max -> saturate, o_err.
//  States: RUN --i_flush, in_cnt==0--> DRAIN; RUN --i_flush, in_cnt!=0--> PAD (macro) or
//   latch flush_pend, enter DRAIN when in_cnt returns to 0. PAD --in_cnt wraps to 0--> DRAIN.
//   DRAIN --flight==0 && !m_valid--> RUN. i_flush in DRAIN/PAD ignored. flight==0 at
//   flush -> DRAIN exits next cycle, no ce issued.
//  o_busy = (state != RUN) || flush_pend || flight != 0.
// CONFIGURATION
//  FFT_STREAM_CTRL_ZEROPAD_EN defined: flush mid-frame enters PAD, completes the partial
//   frame with zero samples (s_ready=0), that frame is counted/drained normally.
//  Not defined: no PAD state; flush mid-frame waits for source to finish the frame
//   (flush_pend), s_ready stays active until in_cnt wraps, then DRAIN.
// TESTING
//  N=8 FFT model, CKPCE=1, s_valid=1 continuous, m_ready=1: o_fft_ce every cycle, o_fft_sync
//   at samples 0,8,16; m_last every 8th m_valid; first m_valid tied to first i_fft_sync.
//  CKPCE=3: s_valid=1 -> o_fft_ce exactly every 3rd cycle, s_ready only on those cycles.
//  m_ready=0 for 5 cycles mid-frame -> no o_fft_ce, m_data stable, no sample lost/duplicated.
//  2 frames in, i_flush at in_cnt==0 -> DRAIN, zeros fed until both results out
//   (2 m_last), o_busy falls, state RUN, s_ready returns.
//  i_flush at in_cnt=3: with macro 5 zero samples then drain; without, waits for 5 source samples.
//  s_last at in_cnt=5 -> o_err=1 until reset; i_reset mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fft_stream_ctrl.sv
// fft_stream_ctrl
//   Schedules a valid/ready sample stream into a CE/sync pipelined FFT and frames
//   the FFT results back into a valid/ready stream with m_last on sample N-1.
//   On i_flush, frames still inside the FFT are pushed out by feeding zero samples.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset (also resets the FFT)
//   s_valid/s_ready/s_data  input sample stream {re,im}; s_last marks sample N-1
//   o_fft_ce/o_fft_sync     FFT clock enable and frame sync (sync only together with ce)
//   o_fft_data              FFT input sample
//   i_fft_sync/i_fft_data   FFT outputs, updated the cycle after each ce
//   m_valid/m_ready/m_data  result stream, m_last on result sample N-1
//   i_flush                 pulse: drain all frames in flight
//   o_busy                  frames in flight, pending flush, or not in RUN
//   o_err                   sticky: misplaced s_last, out-of-frame sync, flight overflow
//
// Build option
//   FFT_STREAM_CTRL_ZEROPAD_EN: a mid-frame flush completes the partial frame with
//   zero samples (PAD state). Without it, the flush waits for the source to finish
//   the current frame before draining.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | source samples feed the FFT, sync on sample 0 of each frame
// PAD   | zero samples complete the current partial frame (option only)
// DRAIN | zero samples push in-flight frames out until none remain
module fft_stream_ctrl #(
    parameter int LGSIZE   = 9,
    parameter int IWIDTH   = 16,
    parameter int OWIDTH   = 21,
    parameter int CKPCE    = 1,
    parameter int LGFLIGHT = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [2*IWIDTH-1:0] s_data,
    input  logic                s_last,
    output logic                o_fft_ce,
    output logic                o_fft_sync,
    output logic [2*IWIDTH-1:0] o_fft_data,
    input  logic                i_fft_sync,
    input  logic [2*OWIDTH-1:0] i_fft_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [2*OWIDTH-1:0] m_data,
    output logic                m_last,
    input  logic                i_flush,
    output logic                o_busy,
    output logic                o_err
);

    localparam logic [LGSIZE-1:0]   LAST_IDX   = '1;
    localparam logic [LGSIZE-1:0]   IDX_ONE    = LGSIZE'(1);
    localparam logic [LGFLIGHT-1:0] FLIGHT_MAX = '1;
    localparam logic [LGFLIGHT-1:0] FLIGHT_ONE = LGFLIGHT'(1);
    localparam logic [1:0]          GAP_LOAD   = 2'(CKPCE - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1
`ifdef FFT_STREAM_CTRL_ZEROPAD_EN
        , ST_PAD = 2'd2
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [LGSIZE-1:0]   in_cnt_q, in_cnt_d;
    logic [LGSIZE-1:0]   out_cnt_q, out_cnt_d;
    logic [LGFLIGHT-1:0] flight_q, flight_d;
    logic [1:0]          gap_q, gap_d;
    logic                hold_q, hold_d;
    logic                fired_q, fired_d;
    logic                flush_pend_q, flush_pend_d;
    logic                err_q, err_d;

    logic                src_ok, fire, frame_end, new_res, accept, inc, dec;
    logic [LGSIZE-1:0]   out_idx;

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        flight_d     = flight_q;
        gap_d        = gap_q;
        flush_pend_d = flush_pend_q;
        err_d        = err_q;
        src_ok       = 1'b0;
        o_fft_data   = '0;

        case (state_q)
            ST_RUN: begin
                // A flush landing exactly on a frame boundary must not open a new frame.
                src_ok     = s_valid && !(i_flush && !flush_pend_q && in_cnt_q == '0);
                o_fft_data = s_data;
            end
            // Nothing left to push out: stay idle so the exit happens without a ce.
            ST_DRAIN: src_ok = (flight_q != '0);
`ifdef FFT_STREAM_CTRL_ZEROPAD_EN
            ST_PAD:   src_ok = 1'b1;
`endif
            default:  src_ok = 1'b0;
        endcase

        // FFT outputs only change after a ce, so a new result can only appear then.
        new_res    = fired_q && (i_fft_sync || out_cnt_q != '0);
        m_valid    = hold_q || new_res;
        fire       = !i_reset && src_ok && (!m_valid || m_ready) && (gap_q == '0);
        o_fft_ce   = fire;
        s_ready    = fire && (state_q == ST_RUN);
        o_fft_sync = s_ready && (in_cnt_q == '0);
        frame_end  = fire && (in_cnt_q == LAST_IDX);

        // A sync always marks result sample 0, even if the count was elsewhere.
        out_idx    = (fired_q && i_fft_sync) ? '0 : out_cnt_q;
        m_last     = m_valid && (out_idx == LAST_IDX);
        m_data     = i_fft_data;
        accept     = m_valid && m_ready;
        hold_d     = m_valid && !m_ready;
        fired_d    = fire;

        if (s_ready && s_last && in_cnt_q != LAST_IDX) err_d = 1'b1;
        if (fired_q && i_fft_sync && out_cnt_q != '0)  err_d = 1'b1;

        if (fire) begin
            in_cnt_d = in_cnt_q + IDX_ONE;
            gap_d    = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 2'd1;
        end

        out_cnt_d = accept ? (out_idx + IDX_ONE) : out_idx;

        inc = o_fft_sync;
        dec = accept && m_last;
        if (inc && !dec) begin
            if (flight_q == FLIGHT_MAX) err_d = 1'b1;
            else                        flight_d = flight_q + FLIGHT_ONE;
        end else if (dec && !inc && flight_q != '0) begin
            flight_d = flight_q - FLIGHT_ONE;
        end

        case (state_q)
            ST_RUN: begin
                if (flush_pend_q) begin
                    if (frame_end) begin
                        state_d      = ST_DRAIN;
                        flush_pend_d = 1'b0;
                    end
                end else if (i_flush) begin
                    if (in_cnt_q == '0 || frame_end) begin
                        state_d = ST_DRAIN;
                    end else begin
`ifdef FFT_STREAM_CTRL_ZEROPAD_EN
                        state_d = ST_PAD;
`else
                        flush_pend_d = 1'b1;
`endif
                    end
                end
            end
`ifdef FFT_STREAM_CTRL_ZEROPAD_EN
            ST_PAD: if (frame_end) state_d = ST_DRAIN;
`endif
            ST_DRAIN: begin
                // Drain zeros advanced in_cnt; the next source frame starts at sample 0.
                if (flight_q == '0 && !m_valid) begin
                    state_d  = ST_RUN;
                    in_cnt_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase

        o_busy = (state_q != ST_RUN) || flush_pend_q || (flight_q != '0);
        o_err  = err_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_RUN;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            flight_q     <= '0;
            gap_q        <= '0;
            hold_q       <= 1'b0;
            fired_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            flight_q     <= flight_d;
            gap_q        <= gap_d;
            hold_q       <= hold_d;
            fired_q      <= fired_d;
            flush_pend_q <= flush_pend_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
module tb_fft_stream_ctrl;

    localparam int LG  = 3;
    localparam int IW  = 16;
    localparam int OW  = 21;
    localparam int LAT = 10;

    logic clk, rst;
    logic s_valid, s_ready, s_last, flush;
    logic [2*IW-1:0] s_data;
    logic o_fft_ce, o_fft_sync, fft_sync;
    logic [2*IW-1:0] o_fft_data;
    logic [2*OW-1:0] fft_data, m_data;
    logic m_valid, m_ready, m_last, o_busy, o_err;

    logic s_valid3, s_ready3, m_ready3, ce3, sync3, mv3, ml3, busy3, err3;
    logic [2*IW-1:0] fdata3;
    logic [2*OW-1:0] md3;

    fft_stream_ctrl #(.LGSIZE(LG), .IWIDTH(IW), .OWIDTH(OW), .CKPCE(1), .LGFLIGHT(4)) dut (
        .i_clk(clk), .i_reset(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .o_fft_ce(o_fft_ce), .o_fft_sync(o_fft_sync), .o_fft_data(o_fft_data),
        .i_fft_sync(fft_sync), .i_fft_data(fft_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .i_flush(flush), .o_busy(o_busy), .o_err(o_err)
    );

    fft_stream_ctrl #(.LGSIZE(LG), .IWIDTH(IW), .OWIDTH(OW), .CKPCE(3), .LGFLIGHT(4)) dut3 (
        .i_clk(clk), .i_reset(rst),
        .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data), .s_last(1'b0),
        .o_fft_ce(ce3), .o_fft_sync(sync3), .o_fft_data(fdata3),
        .i_fft_sync(1'b0), .i_fft_data({2*OW{1'b0}}),
        .m_valid(mv3), .m_ready(m_ready3), .m_data(md3), .m_last(ml3),
        .i_flush(1'b0), .o_busy(busy3), .o_err(err3)
    );

    // FFT stand-in: fixed latency of LAT enables, sample passed through sign-extended.
    logic [2*IW-1:0] pd [LAT];
    logic            ps [LAT];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pd[i] <= '0;
                ps[i] <= 1'b0;
            end
        end else if (o_fft_ce) begin
            pd[0] <= o_fft_data;
            ps[0] <= o_fft_sync;
            for (int i = 1; i < LAT; i++) begin
                pd[i] <= pd[i-1];
                ps[i] <= ps[i-1];
            end
        end
    end
    assign fft_sync = ps[LAT-1];
    assign fft_data = {OW'($signed(pd[LAT-1][2*IW-1:IW])), OW'($signed(pd[LAT-1][IW-1:0]))};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total, bad;
    int n_cyc, n_ce, n_sync, n_hs, n_res, n_last, first_mv, src_k, used;
    logic last_flip;
    logic ce_obs, sync_obs, mv_obs, busy_obs, err_obs, hs_obs;
    logic [2*OW-1:0] md_obs, exp_d;
    logic [2*OW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0; last_flip = 1'b0;
        s_valid3 = 1'b0; m_ready3 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        n_cyc = 0; n_ce = 0; n_sync = 0; n_hs = 0; n_res = 0; n_last = 0;
        first_mv = -1; src_k = 0;
        exp_q.delete();
    endtask

    // One clock: drive source data, observe mid-cycle, score results, advance.
    task automatic cyc();
        s_data = {IW'(src_k), IW'(src_k + 256)};
        s_last = ((src_k % 8) == 7) ^ last_flip;
        #1;
        ce_obs = o_fft_ce; sync_obs = o_fft_sync; mv_obs = m_valid; md_obs = m_data;
        busy_obs = o_busy; err_obs = o_err; hs_obs = s_valid && s_ready;
        if (ce_obs) n_ce++;
        if (sync_obs) begin
            n_sync++;
            chk("sync_pos", 64'(src_k % 8), 64'd0);
        end
        if (hs_obs) begin
            chk("fft_data", 64'(o_fft_data), 64'(s_data));
            exp_q.push_back({OW'(src_k), OW'(src_k + 256)});
            src_k++;
            n_hs++;
        end
        if (mv_obs && first_mv < 0) first_mv = n_cyc;
        if (mv_obs && m_ready) begin
            exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            chk("m_data", 64'(m_data), 64'(exp_d));
            chk("m_last", 64'(m_last), 64'((n_res % 8) == 7));
            chk("m_sync", 64'(fft_sync), 64'((n_res % 8) == 0));
            if (m_last) n_last++;
            n_res++;
        end
        n_cyc++;
        @(posedge clk); #1;
    endtask

    task automatic run_until_idle(input int budget);
        used = 0;
        while (used < budget) begin
            cyc();
            used++;
            if (!busy_obs) break;
        end
        chk("idle_reached", 64'(busy_obs), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0;
        s_data = '0; s_last = 1'b0;

        // reset state
        do_reset();
        cyc();
        chk("rst_ce", 64'(ce_obs), 64'd0);
        chk("rst_mv", 64'(mv_obs), 64'd0);
        chk("rst_busy", 64'(busy_obs), 64'd0);
        chk("rst_err", 64'(err_obs), 64'd0);

        // A: continuous stream, CKPCE=1
        do_reset();
        s_valid = 1'b1; m_ready = 1'b1;
        repeat (30) cyc();
        chk("a_ce", 64'(n_ce), 64'd30);
        chk("a_sync", 64'(n_sync), 64'd4);
        chk("a_res", 64'(n_res), 64'd20);
        chk("a_last", 64'(n_last), 64'd2);
        chk("a_first_mv", 64'(first_mv), 64'd10);
        chk("a_err", 64'(err_obs), 64'd0);

        // B: CKPCE=3 spacing
        do_reset();
        s_valid3 = 1'b1; m_ready3 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("b_ce", 64'(ce3), 64'((i % 3) == 0));
            chk("b_ready", 64'(s_ready3), 64'((i % 3) == 0));
            @(posedge clk); #1;
        end
        s_valid3 = 1'b0;

        // C: downstream stall
        do_reset();
        s_valid = 1'b1; m_ready = 1'b1;
        repeat (12) cyc();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("c_ce", 64'(ce_obs), 64'd0);
            chk("c_mv", 64'(mv_obs), 64'd1);
            chk("c_hold", 64'(md_obs), 64'({OW'(2), OW'(258)}));
        end
        m_ready = 1'b1;
        repeat (15) cyc();
        chk("c_res", 64'(n_res), 64'd17);
        chk("c_hs", 64'(n_hs), 64'd27);
        chk("c_ce_tot", 64'(n_ce), 64'd27);

        // D: two frames, flush on frame boundary
        do_reset();
        s_valid = 1'b1; m_ready = 1'b1;
        repeat (16) cyc();
        chk("d_busy", 64'(busy_obs), 64'd1);
        s_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0; s_valid = 1'b1;
        run_until_idle(100);
        chk("d_res", 64'(n_res), 64'd16);
        chk("d_last", 64'(n_last), 64'd2);
        chk("d_hs", 64'(n_hs), 64'd17);
        chk("d_ce", 64'(n_ce), 64'd27);
        chk("d_ready_back", 64'(hs_obs), 64'd1);
        chk("d_sync_back", 64'(sync_obs), 64'd1);

        // E: flush mid-frame at in_cnt=3
        do_reset();
        s_valid = 1'b1; m_ready = 1'b1;
        repeat (3) cyc();
        s_valid = 1'b0; flush = 1'b1;
`ifdef FFT_STREAM_CTRL_ZEROPAD_EN
        repeat (5) exp_q.push_back('0);
        src_k = src_k + 5;
`endif
        cyc();
        flush = 1'b0; s_valid = 1'b1;
        run_until_idle(100);
`ifdef FFT_STREAM_CTRL_ZEROPAD_EN
        chk("e_hs", 64'(n_hs), 64'd4);
`else
        chk("e_hs", 64'(n_hs), 64'd9);
`endif
        chk("e_res", 64'(n_res), 64'd8);
        chk("e_last", 64'(n_last), 64'd1);
        chk("e_ce", 64'(n_ce), 64'd19);
        chk("e_sync_back", 64'(sync_obs), 64'd1);

        // F: misplaced s_last, then reset mid-frame
        do_reset();
        s_valid = 1'b1; m_ready = 1'b1;
        repeat (5) cyc();
        last_flip = 1'b1;
        cyc();
        chk("f_err_pre", 64'(err_obs), 64'd0);
        last_flip = 1'b0;
        cyc();
        chk("f_err_set", 64'(err_obs), 64'd1);
        cyc();
        chk("f_err_hold", 64'(err_obs), 64'd1);
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("f_rst_ce", 64'(o_fft_ce), 64'd0);
        chk("f_rst_sync", 64'(o_fft_sync), 64'd0);
        chk("f_rst_ready", 64'(s_ready), 64'd0);
        chk("f_rst_mv", 64'(m_valid), 64'd0);
        chk("f_rst_last", 64'(m_last), 64'd0);
        chk("f_rst_mdata", 64'(m_data), 64'd0);
        chk("f_rst_busy", 64'(o_busy), 64'd0);
        chk("f_rst_err", 64'(o_err), 64'd0);
        s_valid = 1'b1;
        #1;
        chk("f_restart_sync", 64'(o_fft_sync), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
